alu_operand_sequencer: RTL and testbench

Upstream control stage for the multi-function ALU datapath. It replaces three separate manual load buttons with one push-button: the raw key is synchronised and debounced, and each confirmed press steps an FSM that issues exactly one single-cycle load strobe per step. The strobes are, in order, `ld_a` (latch `sw` into operand A), `ld_b` (latch `sw` into operand B) and `ld_f` (latch the ALU result and flags). The `stage` output drives status LEDs so the operator knows which load the next press performs.

---
 rtl/alu_seq_pkg.sv | 14 +
 rtl/alu_operand_sequencer_key_debounce.sv | 46 ++++
 rtl/alu_operand_sequencer.sv | 69 ++++++
 tb/tb_alu_operand_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand load sequencer.
// The state encoding doubles as the status LED pattern on the stage output.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        WAIT_F = 2'b10
    } seq_state_t;

    // 10 ms of stable key level at a 50 MHz clock
    localparam int DEB_CNT_DEFAULT = 500000;

endpackage

// File: rtl/alu_operand_sequencer_key_debounce.sv
// Key synchroniser and debouncer: one-cycle press pulse per accepted rising level.
// Latency: 2 sync cycles + DEB_CNT stable cycles; no backpressure, the pulse is not held.
module key_debounce
    import alu_seq_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEFAULT,
    parameter int CNT_W   = $clog2(DEB_CNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    logic             key_s1;
    logic             key_s2;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            deb    <= 1'b0;
            deb_d  <= 1'b0;
            cnt    <= '0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            deb_d  <= deb;
            // A level is accepted only after DEB_CNT consecutive disagreeing cycles
            if (key_s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CNT - 1)) begin
                deb <= key_s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = deb & ~deb_d;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps through A, B and F loads on debounced presses, one registered strobe per step.
// Latency: strobe one cycle after press; ALU_SEQ_AUTO_EXEC_EN makes ld_f follow ld_b automatically.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEFAULT,
    parameter int CNT_W   = $clog2(DEB_CNT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_f,
    output logic [1:0] stage
);

    logic       press;
    seq_state_t state;

    key_debounce #(
        .DEB_CNT (DEB_CNT),
        .CNT_W   (CNT_W)
    ) u_key_debounce (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .press (press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_A;
            ld_a  <= 1'b0;
            ld_b  <= 1'b0;
            ld_f  <= 1'b0;
        end else begin
            ld_a <= 1'b0;
            ld_b <= 1'b0;
            ld_f <= 1'b0;
            case (state)
                WAIT_A: if (press) begin
                    ld_a  <= 1'b1;
                    state <= WAIT_B;
                end
                WAIT_B: if (press) begin
                    ld_b  <= 1'b1;
                    state <= WAIT_F;
                end
`ifdef ALU_SEQ_AUTO_EXEC_EN
                // Transient: any press landing in this cycle is dropped
                WAIT_F: begin
                    ld_f  <= 1'b1;
                    state <= WAIT_A;
                end
`else
                WAIT_F: if (press) begin
                    ld_f  <= 1'b1;
                    state <= WAIT_A;
                end
`endif
                default: state <= WAIT_A;
            endcase
        end
    end

    assign stage = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with DEB_CNT=4: vector table, reset corner cases, random key traffic.
module tb_alu_operand_sequencer;

    localparam int DEB = 4;
`ifdef ALU_SEQ_AUTO_EXEC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic       ld_a;
    logic       ld_b;
    logic       ld_f;
    logic [1:0] stage;

    alu_operand_sequencer #(.DEB_CNT(DEB)) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .ld_a  (ld_a),
        .ld_b  (ld_b),
        .ld_f  (ld_f),
        .stage (stage)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: key history, accepted level, step index 0..2 and expected strobes {a,b,f}
    logic       h0, h1;
    logic       m_deb, m_deb_prev;
    int         m_dis;
    int         m_stage;
    logic [2:0] m_stb;

    // Per-row strobe statistics
    int cnt_a, cnt_b, cnt_f, row_cyc, first_stb;

    typedef struct {
        logic       k;
        int         hold;
        int         ea;
        int         eb;
        int         ef;
        int         first;
        logic [1:0] est;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        h0 = 1'b0; h1 = 1'b0;
        m_deb = 1'b0; m_deb_prev = 1'b0;
        m_dis = 0; m_stage = 0; m_stb = 3'b000;
    endtask

    task automatic model_edge(input logic k);
        logic pr;
        pr    = m_deb & ~m_deb_prev;
        m_stb = 3'b000;
        if (AUTO && m_stage == 2) begin
            m_stb   = 3'b001;
            m_stage = 0;
        end else if (pr) begin
            m_stb   = 3'b100 >> m_stage;
            m_stage = (m_stage + 1) % 3;
        end
        m_deb_prev = m_deb;
        // key as seen two samples ago must disagree DEB times in a row to be accepted
        if (h1 != m_deb) begin
            m_dis++;
            if (m_dis == DEB) begin
                m_deb = h1;
                m_dis = 0;
            end
        end else begin
            m_dis = 0;
        end
        h1 = h0;
        h0 = k;
    endtask

    task automatic cycle(input logic k);
        key = k;
        @(posedge clk);
        model_edge(k);
        @(negedge clk);
        row_cyc++;
        check("outputs", {27'd0, ld_a, ld_b, ld_f, stage}, {27'd0, m_stb, 2'(m_stage)});
        check("onehot", {31'd0, ($countones({ld_a, ld_b, ld_f}) <= 1)}, 32'd1);
        if (ld_a) cnt_a++;
        if (ld_b) cnt_b++;
        if (ld_f) cnt_f++;
        if ((ld_a | ld_b | ld_f) && first_stb == 0) first_stb = row_cyc;
    endtask

    task automatic clear_stats();
        cnt_a = 0; cnt_b = 0; cnt_f = 0; row_cyc = 0; first_stb = 0;
    endtask

    initial begin
        rst = 1'b1;
        key = 1'b0;
        model_reset();
        #1;
        check("reset_out", {27'd0, ld_a, ld_b, ld_f, stage}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back('{1'b0, 20, 0, 0, 0, 0, 2'b00});
        tbl.push_back('{1'b1, 10, 1, 0, 0, 7, 2'b01});
        tbl.push_back('{1'b0, 10, 0, 0, 0, 0, 2'b01});
        tbl.push_back('{1'b1,  1, 0, 0, 0, 0, 2'b01});
        tbl.push_back('{1'b0,  1, 0, 0, 0, 0, 2'b01});
        tbl.push_back('{1'b1,  1, 0, 0, 0, 0, 2'b01});
        tbl.push_back('{1'b0,  1, 0, 0, 0, 0, 2'b01});
        if (AUTO) begin
            tbl.push_back('{1'b1, 10, 0, 1, 1, 7, 2'b00});
            tbl.push_back('{1'b0, 10, 0, 0, 0, 0, 2'b00});
            tbl.push_back('{1'b1, 10, 1, 0, 0, 7, 2'b01});
            tbl.push_back('{1'b0, 10, 0, 0, 0, 0, 2'b01});
        end else begin
            tbl.push_back('{1'b1, 10, 0, 1, 0, 7, 2'b10});
            tbl.push_back('{1'b0, 10, 0, 0, 0, 0, 2'b10});
            tbl.push_back('{1'b1, 10, 0, 0, 1, 7, 2'b00});
            tbl.push_back('{1'b0, 10, 0, 0, 0, 0, 2'b00});
        end

        foreach (tbl[r]) begin
            clear_stats();
            for (int c = 0; c < tbl[r].hold; c++) cycle(tbl[r].k);
            check($sformatf("row%0d_ld_a", r), cnt_a, tbl[r].ea);
            check($sformatf("row%0d_ld_b", r), cnt_b, tbl[r].eb);
            check($sformatf("row%0d_ld_f", r), cnt_f, tbl[r].ef);
            check($sformatf("row%0d_first", r), first_stb, tbl[r].first);
            check($sformatf("row%0d_stage", r), {30'd0, stage}, {30'd0, tbl[r].est});
        end

        // Walk to WAIT_F with the key held, then reset asynchronously
        for (int i = 0; i < 40 && m_stage != 2; i++) cycle((i % 20) < 10);
        for (int i = 0; i < 2 * DEB + 8 && m_stage != 2; i++) cycle(1'b1);
        check("reached_wait_f", {30'd0, stage}, 32'd2);
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_out", {27'd0, ld_a, ld_b, ld_f, stage}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_held_out", {27'd0, ld_a, ld_b, ld_f, stage}, 32'd0);
        rst = 1'b0;
        clear_stats();
        for (int i = 0; i < 15; i++) cycle(1'b1);
        check("held_rst_ld_a_cnt", cnt_a, 1);
        check("held_rst_ld_a_time", first_stb, DEB + 3);
        check("held_rst_stage", {30'd0, stage}, 32'd1);

        // Reset landing while a press is pending must drop the strobe
        for (int i = 0; i < 12; i++) cycle(1'b0);
        key = 1'b1;
        for (int i = 0; i < 2 * DEB + 6 && !(m_deb && !m_deb_prev); i++) cycle(1'b1);
        check("press_pending", {31'd0, m_deb & ~m_deb_prev}, 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("pending_rst_out", {27'd0, ld_a, ld_b, ld_f, stage}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        for (int i = 0; i < 12; i++) cycle(1'b0);
        check("pending_dropped", cnt_a + cnt_b + cnt_f, 0);

        // Random key traffic mixing glitches and real presses
        for (int s = 0; s < 200; s++) begin
            logic k;
            int   hold;
            k    = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 2 * DEB + 3);
            for (int c = 0; c < hold; c++) cycle(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
